// File: rtl/pong_score.sv
// Pong scorekeeper: turns miss levels into single-point events, keeps two BCD
// scores and sequences serve / play / game-over.
module pong_score #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       miss1,
    input  logic       miss2,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [1:0] scored,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       ball_hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        POINT = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [7:0]       WIN_BCD  = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_CYCLES - 1);

    state_t           fsm, fsm_next;
    logic             miss1_d, miss2_d;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [7:0]       score1_next, score2_next;
    logic [1:0]       scored_next, winner_next;
    logic             p1_point, p2_point;
    logic [7:0]       score1_inc, score2_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A miss from player 1 scores for player 2 and vice versa; simultaneous rises cancel.
    assign p1_point   = (miss2 & ~miss2_d) & ~(miss1 & ~miss1_d);
    assign p2_point   = (miss1 & ~miss1_d) & ~(miss2 & ~miss2_d);
    assign score1_inc = bcd_inc(score1);
    assign score2_inc = bcd_inc(score2);

    always_comb begin
        fsm_next    = fsm;
        cnt_next    = cnt;
        score1_next = score1;
        score2_next = score2;
        scored_next = 2'b00;
        winner_next = winner;
        case (fsm)
            IDLE: begin
                score1_next = '0;
                score2_next = '0;
                if (start) fsm_next = PLAY;
            end
            PLAY: begin
                if (p1_point) begin
                    score1_next = score1_inc;
                    scored_next = 2'b10;
                    if (score1_inc == WIN_BCD) begin
                        fsm_next    = OVER;
                        winner_next = 2'b01;
                    end else begin
                        fsm_next = POINT;
                        cnt_next = SERVE_LD;
                    end
                end else if (p2_point) begin
                    score2_next = score2_inc;
                    scored_next = 2'b01;
                    if (score2_inc == WIN_BCD) begin
                        fsm_next    = OVER;
                        winner_next = 2'b10;
                    end else begin
                        fsm_next = POINT;
                        cnt_next = SERVE_LD;
                    end
                end
            end
            POINT: begin
                if (cnt == '0) fsm_next = PLAY;
                else           cnt_next = cnt - CNT_W'(1);
            end
            OVER: begin
                if (start) begin
                    score1_next = '0;
                    score2_next = '0;
                    winner_next = 2'b00;
                    fsm_next    = PLAY;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm       <= IDLE;
            cnt       <= '0;
            score1    <= '0;
            score2    <= '0;
            scored    <= '0;
            winner    <= '0;
            ball_hold <= 1'b1;
            miss1_d   <= 1'b0;
            miss2_d   <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            cnt       <= cnt_next;
            score1    <= score1_next;
            score2    <= score2_next;
            scored    <= scored_next;
            winner    <= winner_next;
            ball_hold <= (fsm_next != PLAY);
            miss1_d   <= miss1;
            miss2_d   <= miss2;
        end
    end

    assign state     = fsm;
    assign game_over = (fsm == OVER);

endmodule

// File: tb/tb_pong_score.sv
// Directed self-checking bench for pong_score: one instance with WIN_SCORE=12,
// one with WIN_SCORE=99 for the saturation / long-game case.
module tb_pong_score;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, miss1_a = 1'b0, miss2_a = 1'b0;
    logic start_b = 1'b0, miss1_b = 1'b0, miss2_b = 1'b0;

    logic [7:0] score1_a, score2_a, score1_b, score2_b;
    logic [1:0] scored_a, winner_a, state_a, scored_b, winner_b, state_b;
    logic       game_over_a, ball_hold_a, game_over_b, ball_hold_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pong_score #(.WIN_SCORE(12), .SERVE_CYCLES(16), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .miss1(miss1_a), .miss2(miss2_a),
        .score1(score1_a), .score2(score2_a), .scored(scored_a), .game_over(game_over_a),
        .winner(winner_a), .ball_hold(ball_hold_a), .state(state_a)
    );

    pong_score #(.WIN_SCORE(99), .SERVE_CYCLES(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .miss1(miss1_b), .miss2(miss2_b),
        .score1(score1_b), .score2(score2_b), .scored(scored_b), .game_over(game_over_b),
        .winner(winner_b), .ball_hold(ball_hold_b), .state(state_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " state"},     32'(state_a),     32'h0);
        check({tag, " score1"},    32'(score1_a),    32'h00);
        check({tag, " score2"},    32'(score2_a),    32'h00);
        check({tag, " scored"},    32'(scored_a),    32'h0);
        check({tag, " game_over"}, 32'(game_over_a), 32'h0);
        check({tag, " winner"},    32'(winner_a),    32'h0);
        check({tag, " ball_hold"}, 32'(ball_hold_a), 32'h1);
    endtask

    initial begin
        int n;
        logic [7:0] exp_bcd;

        #2 reset = 1'b0;
        tick();
        tick();
        check_reset_a("rst");
        check("rst b state", 32'(state_b), 32'h0);
        reset = 1'b1;
        tick();

        // start -> PLAY after one edge
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("start state", 32'(state_a), 32'h1);
        check("start hold", 32'(ball_hold_a), 32'h0);
        check("start score1", 32'(score1_a), 32'h00);

        // single held miss2: one point for player 1
        miss2_a = 1'b1;
        tick();
        check("pt score1", 32'(score1_a), 32'h01);
        check("pt scored", 32'(scored_a), 32'h2);
        check("pt state", 32'(state_a), 32'h2);
        check("pt hold", 32'(ball_hold_a), 32'h1);
        tick();
        check("pt scored fall", 32'(scored_a), 32'h0);
        n = 1;
        while (state_a == 2'b10 && n < 40) begin
            tick();
            n++;
        end
        check("point len", 32'(n), 32'd16);
        check("point exit", 32'(state_a), 32'h1);
        check("play hold", 32'(ball_hold_a), 32'h0);
        repeat (980) tick();
        check("held score1", 32'(score1_a), 32'h01);
        check("held score2", 32'(score2_a), 32'h00);
        check("held state", 32'(state_a), 32'h1);
        miss2_a = 1'b0;
        tick();

        // start held in PLAY does nothing
        start_a = 1'b1;
        tick();
        tick();
        start_a = 1'b0;
        check("start play", 32'(state_a), 32'h1);

        // simultaneous rises cancel
        miss1_a = 1'b1;
        miss2_a = 1'b1;
        tick();
        check("both score1", 32'(score1_a), 32'h01);
        check("both score2", 32'(score2_a), 32'h00);
        check("both scored", 32'(scored_a), 32'h0);
        check("both state", 32'(state_a), 32'h1);
        miss1_a = 1'b0;
        miss2_a = 1'b0;
        tick();

        // player 2 to twelve
        for (int i = 1; i <= 12; i++) begin
            miss1_a = 1'b1;
            tick();
            miss1_a = 1'b0;
            exp_bcd = 8'((i / 10) * 16 + (i % 10));
            check("p2 score", 32'(score2_a), 32'(exp_bcd));
            check("p2 scored", 32'(scored_a), 32'h1);
            if (i < 12) begin
                check("p2 state", 32'(state_a), 32'h2);
                n = 0;
                while (state_a != 2'b01 && n < 40) begin
                    tick();
                    n++;
                end
                check("p2 serve", 32'(n), 32'd16);
            end
        end
        check("carry seen", 32'(score2_a), 32'h12);
        check("over state", 32'(state_a), 32'h3);
        check("over winner", 32'(winner_a), 32'h2);
        check("over flag", 32'(game_over_a), 32'h1);
        check("over hold", 32'(ball_hold_a), 32'h1);
        tick();
        miss1_a = 1'b1;
        tick();
        miss1_a = 1'b0;
        check("over ignore s2", 32'(score2_a), 32'h12);
        check("over ignore st", 32'(state_a), 32'h3);
        check("over ignore pulse", 32'(scored_a), 32'h0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart state", 32'(state_a), 32'h1);
        check("restart s1", 32'(score1_a), 32'h00);
        check("restart s2", 32'(score2_a), 32'h00);
        check("restart winner", 32'(winner_a), 32'h0);
        check("restart flag", 32'(game_over_a), 32'h0);

        // asynchronous reset in the middle of POINT
        miss2_a = 1'b1;
        tick();
        miss2_a = 1'b0;
        tick();
        tick();
        check("pre rst state", 32'(state_a), 32'h2);
        #2 reset = 1'b0;
        #1;
        check_reset_a("async");
        #2;
        tick();
        reset = 1'b1;
        tick();

        // long game on the WIN_SCORE=99 instance
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b start", 32'(state_b), 32'h1);
        for (int i = 1; i <= 99; i++) begin
            miss2_b = 1'b1;
            tick();
            miss2_b = 1'b0;
            if (i == 98) check("b 98", 32'(score1_b), 32'h98);
            n = 0;
            while (state_b == 2'b10 && n < 10) begin
                tick();
                n++;
            end
            if (i < 99) check("b serve", 32'(n), 32'd2);
        end
        check("b sat score", 32'(score1_b), 32'h99);
        check("b over", 32'(state_b), 32'h3);
        check("b winner", 32'(winner_b), 32'h1);
        miss2_b = 1'b1;
        tick();
        miss2_b = 1'b0;
        tick();
        check("b no wrap", 32'(score1_b), 32'h99);
        check("b still over", 32'(state_b), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_score.md
# pong_score

Scorekeeper and match sequencer for the two-player pong game. It sits directly downstream of the multi-player graphics stage and consumes that stage's `miss1`/`miss2` level outputs. From them it derives one-point-per-miss events, holds two BCD scores, and runs the serve/play/game-over state machine. Its `ball_hold` output drives the graphics stage's ball-freeze/recentre logic, and its scores drive the score-overlay renderer.

## Interface
- `WIN_SCORE`, 7 — points needed to win; integer 1..99; compared internally as BCD `{WIN_SCORE/10, WIN_SCORE%10}`.
- `SERVE_CYCLES`, 50_000_000 — pause after a point in clk cycles (0.5 s at 100 MHz); must be ≥ 2.
- `CNT_W`, 26 — serve counter width; must satisfy 2^CNT_W > SERVE_CYCLES.

- `clk` input 1 — system clock; the only clock.
- `reset` input 1 — asynchronous, active-low (0 = reset); all registers clear immediately on assertion.
- `start` input 1 — synchronous, debounced level button; sampled every clk.
- `miss1` input 1 — level from the graphics stage; 1 = player 1 missed, so player 2 scores.
- `miss2` input 1 — level; 1 = player 2 missed, so player 1 scores.
- `score1` output 8 — player 1 score, BCD `{tens[7:4], ones[3:0]}`.
- `score2` output 8 — player 2 score, BCD.
- `scored` output 2 — one-cycle pulse; bit1 = player 1 scored, bit0 = player 2 scored.
- `game_over` output 1 — high in OVER.
- `winner` output 2 — 00 none, 01 player 1, 10 player 2.
- `ball_hold` output 1 — high when the ball must be frozen at centre (IDLE, POINT, OVER).
- `state` output 2 — IDLE=00, PLAY=01, POINT=10, OVER=11.

## Operation
- Edge detect: `miss1_d`/`miss2_d` register the inputs every clk in all states. A rise is `missN & ~missN_d`.
- Because the delay registers track in every state, a miss level still high when PLAY is entered never counts.
- A point is accepted only in PLAY and only when exactly one rise occurs in that cycle.
- Both rises in the same cycle: no point, no `scored` pulse, state unchanged.
- Accepted point:
  - The scorer's BCD value increments: ones 9 → 0 with tens +1.
  - The score saturates at 99.
  - The matching `scored` bit pulses for one cycle.
- State machine:
  - IDLE: scores 00. `start`=1 → PLAY.
  - PLAY: accepted point with new score == WIN_SCORE → OVER; `winner` set.
  - PLAY: accepted point otherwise → POINT; serve counter loaded with SERVE_CYCLES-1.
  - POINT: counter decrements each clk; at 0 → PLAY. Rises are ignored.
  - OVER: scores and `winner` hold. `start`=1 → scores cleared to 00, `winner`=00, → PLAY.
- `start` held high in PLAY or POINT has no effect.
- Reset mid-operation: from any state, asynchronously return to IDLE with every output at its reset value. The counter is cleared.

## Timing
- Reset values:
  - `score1`=`score2`=8'h00
  - `scored`=00
  - `game_over`=0
  - `winner`=00
  - `ball_hold`=1
  - `state`=00
  - `miss1_d`=`miss2_d`=0
  - counter=0
- Point latency: a rise of `missN` that is stable before clk edge k gives the updated score, the `scored` pulse, and the new state after edge k. `scored` falls after edge k+1.
- `ball_hold` is registered and changes on the same edge as `state`.
- POINT duration is exactly SERVE_CYCLES clk cycles, from the edge that enters POINT to the edge that re-enters PLAY.
- `start` → PLAY: 1 clk latency. `ball_hold` falls on the same edge.
- `miss` inputs are already synchronous to clk (they come from the graphics stage registers); no synchronizer is required.

## Test plan
- Reset, then `start`=1 for 1 cycle → state 01 and `ball_hold`=0 after 1 edge; scores 00.
- In PLAY, raise `miss2` and hold it for 1000 cycles:
  - `score1`=01 and `scored`=10 for exactly 1 cycle.
  - State 10 for SERVE_CYCLES (set to 16 in the bench), then 01.
  - Still-high `miss2` adds no second point.
- In PLAY, raise `miss1` and `miss2` on the same cycle → scores unchanged, no pulse, state stays 01.
- WIN_SCORE=12: award player 2 twelve points → `score2` passes 09 → 10 (BCD carry), reaches 12 → state 11, `winner`=10, `game_over`=1. Further rises are ignored. `start` → scores 00, state 01.
- Drive `reset`=0 asynchronously mid-POINT (between clk edges) → all outputs take their reset values immediately, with no clk edge needed.
- WIN_SCORE=99 with a bench-forced long game → score saturates at 99 and enters OVER; no wrap to 00.
